clk_cfg_seq: RTL and testbench

Clock-configuration sequencer that drives the select, divider, PLL-enable and trim inputs of the reset/clock controller. It runs on the always-on 8 MHz clock and accepts a requested clock source and divider over a valid/ready handshake. For each request it parks the system clock on the 8 MHz source, powers and settles the PLL when the PLL is needed, reroutes the source and divider muxes, and releases the park. Every output change therefore lands only while the downstream glitch-free muxes are in a safe state.

---
 rtl/clk_cfg_seq.sv | 141 ++++++++++++++
 tb/tb_clk_cfg_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_cfg_seq.sv
// clk_cfg_seq: clock-configuration sequencer for the reset/clock controller.
// Parks the system clock on the 8 MHz source, optionally powers/retrims the
// PLL, reroutes source and divider muxes, then releases the park, so every
// mux-select change happens while the glitch-free muxes are in a safe state.
module clk_cfg_seq #(
  parameter int unsigned SWITCH_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_src,
  input  logic [1:0] req_div,
  input  logic [1:0] req_trim,
  input  logic [1:0] req_rosc,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_src,
  output logic       sel_8mhz,
  output logic       sel_xclk,
  output logic       sel_pll,
  output logic [1:0] sel_rosc,
  output logic [1:0] clk_div,
  output logic [1:0] pll_trim,
  output logic       pll_en
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PARK    = 3'd1;
  localparam logic [2:0] ST_PLL_ON  = 3'd2;
  localparam logic [2:0] ST_ROUTE   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [CNT_W-1:0] SW_LOAD = CNT_W'(SWITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       r_src, r_div, r_trim, r_rosc;
  logic             r_noop;
  logic             req_noop;
  logic             pll_need;
  logic             wait_over;

  assign req_ready = (state == ST_IDLE);
  assign wait_over = (cnt == '0);

  // Request matches what is already routed: nothing needs to move.
  always_comb begin
    req_noop = (req_src == cur_src) && (req_div == clk_div) &&
               ((req_src != 2'd1) || (req_rosc == sel_rosc)) &&
               ((req_src != 2'd2) || (req_trim == pll_trim));
    pll_need = (r_src == 2'd2) && (!pll_en || (pll_trim != r_trim));
  end

  // Next state, chosen at the exit edge of the current state so skipped
  // states cost no cycles.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (req_valid) nxt = ST_PARK;
      ST_PARK:    if (r_noop) nxt = ST_DONE;
                  else if (wait_over) nxt = pll_need ? ST_PLL_ON : ST_ROUTE;
      ST_PLL_ON:  if (wait_over) nxt = ST_ROUTE;
      ST_ROUTE:   if (wait_over) nxt = (r_src != 2'd0) ? ST_RELEASE : ST_DONE;
      ST_RELEASE: if (wait_over) nxt = ST_DONE;
      ST_DONE:    nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  // State register, wait counter and entry actions of each state.
  // Outputs are written only on the edge that enters a new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      r_src    <= '0;
      r_div    <= '0;
      r_trim   <= '0;
      r_rosc   <= '0;
      r_noop   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_src  <= '0;
      sel_8mhz <= 1'b1;
      sel_xclk <= 1'b0;
      sel_pll  <= 1'b0;
      sel_rosc <= '0;
      clk_div  <= '0;
      pll_trim <= '0;
      pll_en   <= 1'b0;
    end else begin
      state <= nxt;
      done  <= 1'b0;
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      if (nxt != state) begin
        case (nxt)
          ST_PARK: begin
            r_src  <= req_src;
            r_div  <= req_div;
            r_trim <= req_trim;
            r_rosc <= req_rosc;
            r_noop <= req_noop;
            busy   <= 1'b1;
            cnt    <= SW_LOAD;
            // A no-op must not disturb the park select.
            if (!req_noop) sel_8mhz <= 1'b1;
          end
          ST_PLL_ON: begin
            pll_en   <= 1'b1;
            pll_trim <= r_trim;
            cnt      <= ST_LOAD;
          end
          ST_ROUTE: begin
            clk_div  <= r_div;
            sel_xclk <= (r_src == 2'd3);
            sel_pll  <= (r_src == 2'd2);
            if (r_src == 2'd1) sel_rosc <= r_rosc;
            cnt      <= SW_LOAD;
          end
          ST_RELEASE: begin
            sel_8mhz <= 1'b0;
            cnt      <= SW_LOAD;
          end
          ST_DONE: begin
            done    <= 1'b1;
            cur_src <= r_src;
            // sel_pll is already 0 here for any non-PLL source.
            if (r_src != 2'd2) pll_en <= 1'b0;
          end
          default: busy <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_cfg_seq.sv
// tb_clk_cfg_seq: randomized self-checking bench for clk_cfg_seq. Expected
// outputs come from a per-request timeline (event offsets from the accept edge).
module tb_clk_cfg_seq;

  localparam int S = 8;
  localparam int P = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_src = '0, req_div = '0, req_trim = '0, req_rosc = '0;
  logic       busy, done, sel_8mhz, sel_xclk, sel_pll, pll_en;
  logic [1:0] cur_src, sel_rosc, clk_div, pll_trim;

  int checks = 0;
  int errors = 0;

  clk_cfg_seq #(.SWITCH_CYCLES(S), .SETTLE_CYCLES(P), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_div(req_div), .req_trim(req_trim), .req_rosc(req_rosc),
    .busy(busy), .done(done), .cur_src(cur_src), .sel_8mhz(sel_8mhz),
    .sel_xclk(sel_xclk), .sel_pll(sel_pll), .sel_rosc(sel_rosc),
    .clk_div(clk_div), .pll_trim(pll_trim), .pll_en(pll_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready, busy, done;
    logic [1:0] cur;
    logic       s8, xclk, spll;
    logic [1:0] rosc, div, trim;
    logic       pll;
  } obs_t;

  obs_t obs, expv;
  assign obs = {req_ready, busy, done, cur_src, sel_8mhz, sel_xclk, sel_pll,
                sel_rosc, clk_div, pll_trim, pll_en};

  // Model of what the clock controller currently sees.
  logic [1:0] m_src, m_div, m_rosc, m_trim;
  logic       m_pll, m_s8, m_xclk, m_spll;
  // Current request and its event offsets from the accept edge.
  logic [1:0] r_src, r_div, r_trim, r_rosc;
  bit         r_noop, r_pll;
  int         tR, tRel, tD;

  task automatic reset_model();
    m_src = 0; m_div = 0; m_rosc = 0; m_trim = 0;
    m_pll = 0; m_s8 = 1; m_xclk = 0; m_spll = 0;
    r_noop = 0; r_pll = 0; tR = 0; tRel = 0; tD = 0;
  endtask

  // Expected outputs k cycles after the accept edge (k<0: idle view).
  function automatic obs_t expect_at(int k);
    obs_t e;
    e = {1'b1, 1'b0, 1'b0, m_src, m_s8, m_xclk, m_spll, m_rosc, m_div, m_trim, m_pll};
    if (k < 0) return e;
    if (r_noop) begin
      e.ready = (k >= 2); e.busy = (k <= 1); e.done = (k == 1);
      return e;
    end
    e.ready = (k > tD); e.busy = (k <= tD); e.done = (k == tD);
    e.s8 = (r_src != 0 && k >= tRel) ? 1'b0 : 1'b1;
    if (r_pll && k >= S) begin e.pll = 1'b1; e.trim = r_trim; end
    if (k >= tR) begin
      e.div  = r_div;
      e.xclk = (r_src == 3);
      e.spll = (r_src == 2);
      if (r_src == 1) e.rosc = r_rosc;
    end
    if (k >= tD) begin
      e.cur = r_src;
      if (r_src != 2) e.pll = 1'b0;
    end
    return e;
  endfunction

  task automatic commit();
    obs_t e;
    e = expect_at(tD + 1);
    m_src = e.cur; m_div = e.div; m_rosc = e.rosc; m_trim = e.trim;
    m_pll = e.pll; m_s8 = e.s8; m_xclk = e.xclk; m_spll = e.spll;
  endtask

  // Plan a request from the model, present it, and step to the accept edge + 1.
  task automatic issue(input logic [1:0] src, input logic [1:0] div,
                       input logic [1:0] trim, input logic [1:0] rosc);
    r_src = src; r_div = div; r_trim = trim; r_rosc = rosc;
    r_noop = (src == m_src) && (div == m_div) && (src != 1 || rosc == m_rosc) &&
             (src != 2 || trim == m_trim);
    r_pll  = !r_noop && src == 2 && (!m_pll || m_trim != trim);
    tR     = S + (r_pll ? P : 0);
    tRel   = tR + S;
    tD     = r_noop ? 1 : ((src != 0) ? tRel + S : tR + S);
    req_src = src; req_div = div; req_trim = trim; req_rosc = rosc;
    req_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic scramble_inputs();
    req_src   = 2'($urandom_range(0, 3));
    req_div   = 2'($urandom_range(0, 3));
    req_trim  = 2'($urandom_range(0, 3));
    req_rosc  = 2'($urandom_range(0, 3));
    req_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    reset_model();
    rst = 1'b1;
    #2;
    expv = expect_at(-1);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", obs, expv);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", obs, expv);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Test-plan sequences; each runs its full timeline cycle by cycle.
  task automatic test_directed();
    logic [1:0] seq [6][4];
    bit         scr [6];
    seq[0] = '{2'd1, 2'd2, 2'd0, 2'd3}; scr[0] = 0;
    seq[1] = '{2'd2, 2'd2, 2'd1, 2'd0}; scr[1] = 0;
    seq[2] = '{2'd3, 2'd1, 2'd0, 2'd0}; scr[2] = 0;
    seq[3] = '{2'd3, 2'd1, 2'd2, 2'd1}; scr[3] = 0;
    seq[4] = '{2'd2, 2'd1, 2'd3, 2'd0}; scr[4] = 0;
    seq[5] = '{2'd0, 2'd3, 2'd0, 2'd0}; scr[5] = 1;
    for (int n = 0; n < 6; n++) begin
      issue(seq[n][0], seq[n][1], seq[n][2], seq[n][3]);
      for (int k = 0; k <= tD + 1; k++) begin
        expv = expect_at(k);
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL directed[%0d] k=%0d: got %h want %h", n, k, obs, expv);
        end
        if (scr[n] && k < tD) scramble_inputs();
        else req_valid = 1'b0;
        if (k <= tD) begin @(posedge clk); #1; end
      end
      commit();
    end
  endtask

  // Random requests back to back, with req_* scrambled while busy.
  task automatic test_random();
    logic [1:0] s, d, t, r;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = m_src; d = m_div; t = m_trim; r = m_rosc;
      end else begin
        s = 2'($urandom_range(0, 3)); d = 2'($urandom_range(0, 3));
        t = 2'($urandom_range(0, 3)); r = 2'($urandom_range(0, 3));
      end
      issue(s, d, t, r);
      for (int k = 0; k <= tD + 1; k++) begin
        expv = expect_at(k);
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL random[%0d] src=%0d k=%0d: got %h want %h", n, s, k, obs, expv);
        end
        if (k < tD) scramble_inputs();
        else req_valid = 1'b0;
        if (k <= tD) begin @(posedge clk); #1; end
      end
      commit();
    end
  endtask

  // Reset lands in the middle of a PLL sequence; then a normal request.
  task automatic test_reset_midseq();
    issue(2'd2, 2'd1, m_trim + 2'd1, 2'd0);
    req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      expv = expect_at(k);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL midseq_pre k=%0d: got %h want %h", k, obs, expv);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    reset_model();
    expv = expect_at(-1);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL midseq_async_reset: got %h want %h", obs, expv);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL midseq_reset_hold k=%0d: got %h want %h", k, obs, expv);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    issue(2'd1, 2'd3, 2'd0, 2'd2);
    for (int k = 0; k <= tD + 1; k++) begin
      expv = expect_at(k);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL midseq_after k=%0d: got %h want %h", k, obs, expv);
      end
      req_valid = 1'b0;
      if (k <= tD) begin @(posedge clk); #1; end
    end
    commit();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midseq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
